// File: rtl/control_sequencer.sv
// control_sequencer: Mini SRC fetch/execute T-state sequencer driving register selects and datapath strobes.
// Optional CU_SINGLE_STEP_EN adds a step port and an IDLE state between instructions.
module control_sequencer #(
  parameter int ALU_OP_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         IR,
  input  logic                mem_done,
`ifdef CU_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Cout,
  output logic                Read,
  output logic                Write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                run,
  output logic                bad_op
);
  typedef enum logic [3:0] {
`ifdef CU_SINGLE_STEP_EN
    IDLE,
`endif
    F0, F1, F2, F3, E0, E1, E2, E3, E4, HALT
  } state_t;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
    OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01010, OP_OR = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110, OP_JR = 5'b10100,
    OP_NOP = 5'b11010, OP_HALT = 5'b11011;
`ifdef CU_SINGLE_STEP_EN
  localparam state_t START = IDLE;
`else
  localparam state_t START = F0;
`endif
  state_t state_q, state_d;
  logic [4:0] op, i_alu;
  logic is_r, is_i, is_mem;
  logic [26:0] unused_ir;
  assign unused_ir = IR[26:0];
  assign op = IR[31:27];
  assign is_r = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR;
  assign is_i = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
  assign is_mem = op == OP_LD || op == OP_LDI || op == OP_ST;
  assign i_alu = op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : OP_ADD;
  always_comb begin
    state_d = state_q;
    {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
     IRin, Yin, Zin, Zlowout, Cout, Read, Write, bad_op} = '0;
    alu_op = '0;
    run = state_q != HALT;
    case (state_q)
`ifdef CU_SINGLE_STEP_EN
      IDLE: state_d = step ? F0 : IDLE;
`endif
      F0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        alu_op = ALU_OP_W'(OP_ADD);
        state_d = F1;
      end
      F1: begin
        {Zlowout, PCin} = '1;
        state_d = F2;
      end
      F2: begin
        {Read, MDRin} = '1;
        state_d = mem_done ? F3 : F2;
      end
      F3: begin
        {MDRout, IRin} = '1;
        state_d = E0;
      end
      E0: begin
        // Only the multi-step classes continue to E1; everything else retires here.
        state_d = START;
        if (is_r || is_i) {Grb, Rout, Yin} = '1;
        else if (is_mem) {Grb, BAout, Yin} = '1;
        else if (op == OP_JR) {Gra, Rout, PCin} = '1;
        else if (op == OP_HALT) state_d = HALT;
        else if (op != OP_NOP) bad_op = 1'b1;
        if (is_r || is_i || is_mem) state_d = E1;
      end
      E1: begin
        Zin = 1'b1;
        if (is_r) {Grc, Rout} = '1;
        else Cout = 1'b1;
        alu_op = ALU_OP_W'(is_r ? op : is_i ? i_alu : OP_ADD);
        state_d = E2;
      end
      E2: begin
        Zlowout = 1'b1;
        if (op == OP_LD || op == OP_ST) begin
          MARin = 1'b1;
          state_d = E3;
        end else begin
          {Gra, Rin} = '1;
          state_d = START;
        end
      end
      E3: begin
        if (op == OP_ST) {Gra, Rout, MDRin} = '1;
        else {Read, MDRin} = '1;
        state_d = (op == OP_ST || mem_done) ? E4 : E3;
      end
      E4: begin
        if (op == OP_ST) Write = 1'b1;
        else {MDRout, Gra, Rin} = '1;
        state_d = (op != OP_ST || mem_done) ? START : E4;
      end
      default: ;
    endcase
    if (clear) begin
      state_d = START;
      {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
       IRin, Yin, Zin, Zlowout, Cout, Read, Write, bad_op, run} = '0;
      alu_op = '0;
    end
  end
  always_ff @(posedge clock) state_q <= state_d;
endmodule
